// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the register-bank bus: source slot numbering,
// read controller state encoding and a population-count helper.
package cpu_bus_pkg;

  // Bit positions in the flattened bus-source vector, highest priority first.
  localparam int SRC_C      = 0;
  localparam int SRC_INPORT = 1;
  localparam int SRC_MDR    = 2;
  localparam int SRC_REG0   = 3;
  localparam int MAX_SRCS   = 64;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } rd_state_t;

  function automatic logic [31:0] count_ones(input logic [MAX_SRCS-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAX_SRCS; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mdr_read_ctrl.sv
// Memory read sequencer for the MDR: request/acknowledge handshake with a
// bounded wait, address latch and sticky timeout flag.
//
// state | meaning
// IDLE  | no read outstanding; mem_read latches MAR and starts a request
// REQ   | mem_req held high; waits for mem_ack or timer terminal count
module mdr_read_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             mem_read,
  input  logic [WIDTH-1:0] mar,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_req,
  output logic             mdr_busy,
  output logic             mem_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mdr_load,
  output logic [WIDTH-1:0] mdr_data
);

  // Down-counter reaches zero on the TIMEOUT-th edge spent in REQ.
  localparam logic [7:0] TC_LOAD = 8'(TIMEOUT - 1);

  rd_state_t  state;
  logic [7:0] timer;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      timer    <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      mdr_busy <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read) begin
            state    <= REQ;
            mem_addr <= mar;
            timer    <= TC_LOAD;
            mem_req  <= 1'b1;
            mdr_busy <= 1'b1;
          end
        end
        REQ: begin
          // Ack is tested first so it beats a coincident expiry.
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mdr_busy <= 1'b0;
          end else if (timer == 8'd0) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mdr_busy <= 1'b0;
            mem_err  <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          mem_req  <= 1'b0;
          mdr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign mdr_load = (state == REQ) && mem_ack;
  assign mdr_data = mem_rdata;

endmodule

// File: rtl/reg_bank_bus.sv
// General-register bank around a single shared bus with MAR and MDR; the MDR
// can also be filled from memory through mdr_read_ctrl.
module reg_bank_bus
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 0,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NREGS-1:0] reg_in,
  input  logic [NREGS-1:0] reg_out,
  input  logic             mar_in,
  input  logic             mdr_in,
  input  logic             mdr_out,
  input  logic             inport_out,
  input  logic             c_out,
  input  logic [WIDTH-1:0] inport_data,
  input  logic [WIDTH-1:0] c_sign_extend,
  input  logic             mem_read,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mdr_busy,
  output logic             mem_err,
  output logic [WIDTH-1:0] bus,
  output logic             bus_err
);

  logic [WIDTH-1:0]    regs [NREGS];
  logic [WIDTH-1:0]    mar;
  logic [WIDTH-1:0]    mdr;
  logic [WIDTH-1:0]    bus_c;
  logic [MAX_SRCS-1:0] src;
  logic                mdr_load;
  logic [WIDTH-1:0]    mdr_data;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    // A hardwired-zero R0 keeps its flop but never accepts a write.
    localparam bit WR_EN = !(i == 0 && R0_ZERO != 0);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        q <= '0;
      end else if (reg_in[i] && WR_EN) begin
        q <= bus_c;
      end
    end

    assign regs[i] = q;
  end

  always_comb begin
    src              = '0;
    src[SRC_C]       = c_out;
    src[SRC_INPORT]  = inport_out;
    src[SRC_MDR]     = mdr_out;
    for (int i = 0; i < NREGS; i++) begin
      src[SRC_REG0 + i] = reg_out[i];
    end
  end

  // Walk from lowest priority to highest so the last match wins.
  always_comb begin
    bus_c = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (reg_out[i]) bus_c = regs[i];
    end
    if (mdr_out)    bus_c = mdr;
    if (inport_out) bus_c = inport_data;
    if (c_out)      bus_c = c_sign_extend;
  end

  assign bus = bus_c;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_err <= 1'b0;
    end else if (count_ones(src) > 32'd1) begin
      bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mar <= '0;
    end else if (mar_in) begin
      mar <= bus_c;
    end
  end

  // Memory data owns the MDR while a read is outstanding.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mdr <= '0;
    end else if (mdr_load) begin
      mdr <= mdr_data;
    end else if (mdr_in && !mdr_busy) begin
      mdr <= bus_c;
    end
  end

  mdr_read_ctrl #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) u_rd_ctrl (
    .clk      (clk),
    .clr      (clr),
    .mem_read (mem_read),
    .mar      (mar),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .mem_req  (mem_req),
    .mdr_busy (mdr_busy),
    .mem_err  (mem_err),
    .mem_addr (mem_addr),
    .mdr_load (mdr_load),
    .mdr_data (mdr_data)
  );

endmodule

// File: tb/tb_reg_bank_bus.sv
// Bench for reg_bank_bus: a 16-register TIMEOUT=4 instance plus a
// 32-register hardwired-zero-R0 instance sharing most control inputs.
`timescale 1ns/1ps
module tb_reg_bank_bus;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr;
  logic [15:0]   reg_in, reg_out;
  logic          mar_in, mdr_in, mdr_out, inport_out, c_out, mem_read, mem_ack;
  logic [W-1:0]  inport_data, c_sign_extend, mem_rdata;
  logic          mem_req, mdr_busy, mem_err, bus_err;
  logic [W-1:0]  mem_addr, bus;

  logic [31:0]   z_reg_in, z_reg_out;
  logic          z_mem_req, z_mdr_busy, z_mem_err, z_bus_err;
  logic [W-1:0]  z_mem_addr, z_bus;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs, e;

  always #5 clk = ~clk;

  reg_bank_bus #(.WIDTH(W), .NREGS(16), .R0_ZERO(0), .TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .inport_out(inport_out), .c_out(c_out), .inport_data(inport_data),
    .c_sign_extend(c_sign_extend), .mem_read(mem_read), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mdr_busy(mdr_busy), .mem_err(mem_err), .bus(bus), .bus_err(bus_err)
  );

  reg_bank_bus #(.WIDTH(W), .NREGS(32), .R0_ZERO(1), .TIMEOUT(15)) dut_z (
    .clk(clk), .clr(clr), .reg_in(z_reg_in), .reg_out(z_reg_out),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .inport_out(inport_out), .c_out(c_out), .inport_data(inport_data),
    .c_sign_extend(c_sign_extend), .mem_read(mem_read), .mem_req(z_mem_req),
    .mem_addr(z_mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mdr_busy(z_mdr_busy), .mem_err(z_mem_err), .bus(z_bus), .bus_err(z_bus_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    reg_in = '0; reg_out = '0; z_reg_in = '0; z_reg_out = '0;
    mar_in = 0; mdr_in = 0; mdr_out = 0; inport_out = 0; c_out = 0;
    mem_read = 0; mem_ack = 0;
    inport_data = '0; c_sign_extend = '0; mem_rdata = '0;
  endtask

  task automatic rd(input int i, output logic [W-1:0] v);
    reg_out = '0; reg_out[i] = 1'b1;
    #1 v = bus;
    reg_out = '0;
  endtask

  task automatic rd_z(input int i, output logic [W-1:0] v);
    z_reg_out = '0; z_reg_out[i] = 1'b1;
    #1 v = z_bus;
    z_reg_out = '0;
  endtask

  task automatic rd_mdr(output logic [W-1:0] v);
    mdr_out = 1'b1;
    #1 v = bus;
    mdr_out = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    idle_inputs();
    #2;
    exp_q.push_back(32'h0); obs = bus;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_bus: got %h expected %h", obs, e); end
    exp_q.push_back(32'h0); obs = {28'b0, mem_req, mdr_busy, mem_err, bus_err};
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_flags: got %h expected %h", obs, e); end
    exp_q.push_back(32'h0); obs = mem_addr;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mem_addr: got %h expected %h", obs, e); end
    tick();
    clr = 1'b0;
    tick();
    exp_q.push_back(32'h0); rd(5, obs);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_r5: got %h expected %h", obs, e); end
    exp_q.push_back(32'h0); rd_mdr(obs);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mdr: got %h expected %h", obs, e); end
  endtask

  task automatic test_transfers;
    c_sign_extend = 32'hFFFF_FF80; c_out = 1; reg_in[3] = 1;
    exp_q.push_back(32'hFFFF_FF80);
    tick(); idle_inputs();
    rd(3, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL xfer_c_to_r3: got %h expected %h", obs, e); end
    tick();
    reg_out[3] = 1; reg_in[7] = 1;
    exp_q.push_back(32'hFFFF_FF80);
    tick(); idle_inputs();
    rd(7, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL xfer_r3_to_r7: got %h expected %h", obs, e); end
    tick();
    reg_out[7] = 1; reg_in[7] = 1;
    exp_q.push_back(32'hFFFF_FF80);
    tick(); idle_inputs();
    rd(7, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL self_load_r7: got %h expected %h", obs, e); end
    tick();
    inport_data = 32'h11; inport_out = 1; reg_in[2] = 1; tick(); idle_inputs();
    inport_data = 32'h22; inport_out = 1; reg_in[5] = 1; tick(); idle_inputs();
    inport_data = 32'h55; inport_out = 1; reg_in[0] = 1;
    exp_q.push_back(32'h55);
    tick(); idle_inputs();
    rd(0, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL r0_writable: got %h expected %h", obs, e); end
    tick();
    inport_data = 32'h33; inport_out = 1; reg_in[10] = 1; reg_in[11] = 1;
    exp_q.push_back(32'h33); exp_q.push_back(32'h33);
    tick(); idle_inputs();
    rd(10, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL multi_dest_r10: got %h expected %h", obs, e); end
    rd(11, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL multi_dest_r11: got %h expected %h", obs, e); end
  endtask

  task automatic test_collision;
    tick();
    exp_q.push_back(32'h0); obs = {31'b0, bus_err};
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL no_err_before: got %h expected %h", obs, e); end
    reg_out[2] = 1; reg_out[5] = 1;
    #1;
    exp_q.push_back(32'h11); obs = bus;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL collision_bus: got %h expected %h", obs, e); end
    exp_q.push_back(32'h0); obs = {31'b0, bus_err};
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL err_before_edge: got %h expected %h", obs, e); end
    tick(); idle_inputs();
    exp_q.push_back(32'h1); obs = {31'b0, bus_err};
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL collision_err: got %h expected %h", obs, e); end
    tick();
    exp_q.push_back(32'h1); obs = {31'b0, bus_err};
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL err_sticky: got %h expected %h", obs, e); end
    reg_out[5] = 1; reg_in[9] = 1;
    exp_q.push_back(32'h22);
    tick(); idle_inputs();
    rd(9, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL post_collision_xfer: got %h expected %h", obs, e); end
    tick();
    c_sign_extend = 32'h1234; inport_data = 32'h5678;
    c_out = 1; inport_out = 1; reg_out[2] = 1;
    #1;
    exp_q.push_back(32'h1234); obs = bus;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_c: got %h expected %h", obs, e); end
    c_out = 0;
    #1;
    exp_q.push_back(32'h5678); obs = bus;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_inport: got %h expected %h", obs, e); end
    inport_out = 0; mdr_out = 1;
    #1;
    exp_q.push_back(32'h0); obs = bus;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL prio_mdr: got %h expected %h", obs, e); end
    idle_inputs();
  endtask

  task automatic test_mem_read;
    tick();
    inport_data = 32'h40; inport_out = 1; mar_in = 1;
    tick(); idle_inputs();
    mem_read = 1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h40); exp_q.push_back(32'h1);
    tick(); idle_inputs();
    obs = {31'b0, mem_req}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL req_high: got %h expected %h", obs, e); end
    obs = mem_addr; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL addr_latched: got %h expected %h", obs, e); end
    obs = {31'b0, mdr_busy}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL busy_high: got %h expected %h", obs, e); end
    inport_data = 32'h80; inport_out = 1; mar_in = 1; mdr_in = 1;
    exp_q.push_back(32'h40); exp_q.push_back(32'h0);
    tick(); idle_inputs();
    obs = mem_addr; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL addr_held: got %h expected %h", obs, e); end
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mdr_in_ignored_busy: got %h expected %h", obs, e); end
    tick();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0); exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
    tick(); idle_inputs();
    obs = {30'b0, mem_req, mdr_busy}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL req_dropped: got %h expected %h", obs, e); end
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mdr_loaded: got %h expected %h", obs, e); end
    obs = {31'b0, mem_err}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL no_err_on_ack: got %h expected %h", obs, e); end
    tick();
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    exp_q.push_back(32'h0); exp_q.push_back(32'hDEAD_BEEF);
    tick(); idle_inputs();
    obs = {31'b0, mem_req}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL idle_ack_no_req: got %h expected %h", obs, e); end
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL idle_ack_ignored: got %h expected %h", obs, e); end
  endtask

  task automatic test_timeout;
    int n;
    tick();
    mem_read = 1;
    exp_q.push_back(32'h80);
    tick(); idle_inputs();
    obs = mem_addr; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL addr_from_updated_mar: got %h expected %h", obs, e); end
    exp_q.push_back(32'd4); exp_q.push_back(32'h1); exp_q.push_back(32'hDEAD_BEEF);
    n = 0;
    for (int c = 0; c < 20 && mem_req; c++) begin
      n++;
      tick();
    end
    obs = 32'(n); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL req_cycles: got %0d expected %0d", obs, e); end
    obs = {31'b0, mem_err}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL timeout_err: got %h expected %h", obs, e); end
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mdr_unchanged_timeout: got %h expected %h", obs, e); end
    tick();
    mem_read = 1;
    tick(); idle_inputs();
    tick(); tick(); tick();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    exp_q.push_back(32'h0); exp_q.push_back(32'hCAFE_F00D); exp_q.push_back(32'h1);
    tick(); idle_inputs();
    obs = {31'b0, mem_req}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL expiry_ack_req: got %h expected %h", obs, e); end
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL expiry_ack_mdr: got %h expected %h", obs, e); end
    obs = {31'b0, mem_err}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mem_err_sticky: got %h expected %h", obs, e); end
    tick();
    inport_data = 32'h5A; inport_out = 1; mdr_in = 1;
    exp_q.push_back(32'h5A);
    tick(); idle_inputs();
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL mdr_from_bus: got %h expected %h", obs, e); end
  endtask

  task automatic test_r0_zero;
    tick();
    inport_data = 32'h55; inport_out = 1; z_reg_in[0] = 1;
    exp_q.push_back(32'h0);
    tick(); idle_inputs();
    rd_z(0, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL r0_zero_read: got %h expected %h", obs, e); end
    tick();
    inport_data = 32'hA5A5_A5A5; inport_out = 1; z_reg_in[31] = 1;
    exp_q.push_back(32'hA5A5_A5A5);
    tick(); idle_inputs();
    rd_z(31, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL r31_readback: got %h expected %h", obs, e); end
    z_reg_out[0] = 1; z_reg_out[31] = 1;
    exp_q.push_back(32'h0);
    #1 obs = z_bus; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL r0_zero_priority: got %h expected %h", obs, e); end
    idle_inputs();
  endtask

  task automatic test_clr_mid;
    tick();
    mem_read = 1;
    tick(); idle_inputs();
    tick();
    exp_q.push_back(32'h1);
    obs = {31'b0, mem_req}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL pre_clr_req: got %h expected %h", obs, e); end
    clr = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    obs = {31'b0, mem_req}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL clr_async_req: got %h expected %h", obs, e); end
    obs = {29'b0, mdr_busy, mem_err, bus_err}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL clr_flags: got %h expected %h", obs, e); end
    obs = mem_addr; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL clr_mem_addr: got %h expected %h", obs, e); end
    rd(3, obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL clr_r3: got %h expected %h", obs, e); end
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL clr_mdr: got %h expected %h", obs, e); end
    clr = 1'b0;
    mem_ack = 1; mem_rdata = 32'h77;
    exp_q.push_back(32'h0);
    tick(); idle_inputs();
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL lost_ack: got %h expected %h", obs, e); end
    tick();
    mem_read = 1;
    tick(); idle_inputs();
    tick(); tick(); tick();
    mem_ack = 1; mem_rdata = 32'h99;
    exp_q.push_back(32'h0); exp_q.push_back(32'h99);
    tick(); idle_inputs();
    obs = {31'b0, mem_err}; e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ack_wins_no_err: got %h expected %h", obs, e); end
    rd_mdr(obs); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ack_wins_mdr: got %h expected %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_transfers();
    test_collision();
    test_mem_read();
    test_timeout();
    test_r0_zero();
    test_clr_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
